// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 8-bit datapath: fetch/decode/execute/memory/writeback
// sequencing with a bounded memory-ready wait, a sticky timeout flag and a retire counter.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             pc_src,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             halted,
  output logic             mem_error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_ADDI = 3'b010,
    OP_LW   = 3'b011,
    OP_SW   = 3'b100,
    OP_BEQ  = 3'b101,
    OP_NOP  = 3'b110,
    OP_HALT = 3'b111
  } op_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  // Extra headroom bit so the counter can hold MEM_TIMEOUT even when it is a power of two minus one.
  localparam int              WAIT_W     = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q;
  logic               mem_error_q;

  logic               retire;
  logic               timeout;
  logic               wait_expired;
  logic               waiting;

  logic               pc_write_c, pc_src_c, ir_write_c, reg_write_c, alu_src_c;
  logic [1:0]         alu_op_c;
  logic               mem_read_c, mem_write_c, mem_to_reg_c, halted_c;

  assign wait_expired = (wait_q == WAIT_LIMIT) && !mem_ready;
  assign waiting      = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    retire       = 1'b0;
    timeout      = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_c    = 1'b0;
    alu_op_c     = ALU_ADD;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    halted_c     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_expired) begin
          timeout = 1'b1;
          state_d = S_HALT;
        end
      end

      S_DECODE: begin
        op_d = op_t'(opcode);
        case (op_t'(opcode))
          OP_NOP: begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_HALT: begin
            retire  = 1'b1;
            state_d = S_HALT;
          end
          default: state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (op_q)
          OP_ADD: begin
            state_d = S_WB;
          end
          OP_SUB: begin
            alu_op_c = ALU_SUB;
            state_d  = S_WB;
          end
          OP_ADDI: begin
            alu_src_c = 1'b1;
            state_d   = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_c = 1'b1;
            state_d   = S_MEM;
          end
          OP_BEQ: begin
            alu_op_c = ALU_SUB;
            if (zero) begin
              pc_write_c = 1'b1;
              pc_src_c   = 1'b1;
            end
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        if (op_q == OP_SW) mem_write_c = 1'b1;
        else               mem_read_c  = 1'b1;
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          timeout = 1'b1;
          state_d = S_HALT;
        end
      end

      S_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = (op_q == OP_LW);
        retire       = 1'b1;
        state_d      = S_FETCH;
      end

      S_HALT: begin
        halted_c = 1'b1;
      end

      // Codes 6 and 7 recover to FETCH with all strobes idle.
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) wait_d = '0;
    else if (waiting)       wait_d = wait_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      op_q        <= OP_ADD;
      wait_q      <= '0;
      retired_q   <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      retired_q <= retired_q + CNT_W'(retire);
      if (timeout) mem_error_q <= 1'b1;
    end
  end

  // Strobes are idle for the whole time reset is held, whatever state is registered.
  assign PCWrite   = pc_write_c   & ~reset;
  assign pc_src    = pc_src_c     & ~reset;
  assign IRWrite   = ir_write_c   & ~reset;
  assign RegWrite  = reg_write_c  & ~reset;
  assign ALUSrc    = alu_src_c    & ~reset;
  assign ALUOp     = alu_op_c     & {2{~reset}};
  assign MemRead   = mem_read_c   & ~reset;
  assign MemWrite  = mem_write_c  & ~reset;
  assign MemtoReg  = mem_to_reg_c & ~reset;
  assign halted    = halted_c     & ~reset;

  assign mem_error = mem_error_q;
  assign state     = state_q;
  assign retired   = retired_q;

endmodule
